dot_acc8: RTL and testbench
===========================

Name: dot_acc8

Overview:
- Downstream consumer of the 8x8 shift-add multiplier.
- Accumulates a vector of N_TERMS 16-bit products into a dot-product sum, one product per prod_vld strobe.
- Presents each completed sum on a valid/ready output register, so the multiplier's fixed-rate results can feed back-pressured logic.
- Accumulation of the next vector continues while a completed sum waits for its handshake.

Parameters:
- N_TERMS, 8: products per vector; 2 to 256.
- ACC_W, 20: accumulator/sum width.
  - Must satisfy ACC_W >= 16 + clog2(N_TERMS).
  - Elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- prod_in  in  16  unsigned product from the multiplier.
- prod_vld  in  1  one-cycle strobe: prod_in valid this cycle.
- clr  in  1  synchronous abort; discards the partial vector.
- sum_out  out  ACC_W  completed vector sum.
- sum_vld  out  1  sum_out holds an unconsumed sum.
- sum_rdy  in  1  consumer accepts sum_out when sum_vld && sum_rdy.
- busy  out  1  partial vector in progress (state == ACC).
- term_cnt  out  clog2(N_TERMS)  products accumulated in the current vector.
- ovr  out  1  sticky: a completed sum was dropped.

Behaviour:
- Reset (async, rst=1): every register, including all outputs, is zero and state = IDLE. Release takes effect at the first clk edge after rst falls.
- FSM states: IDLE, ACC.
  - IDLE: acc=0, term_cnt=0.
    - prod_vld -> acc=prod_in, term_cnt=1, go to ACC.
    - If N_TERMS==1 is disallowed by the range, so IDLE never completes a vector.
  - ACC, on prod_vld: acc += prod_in (zero-extended to ACC_W), term_cnt++.
    - Vector completes on the prod_vld that brings term_cnt to N_TERMS.
    - On completion: final value = acc + prod_in, acc=0, term_cnt=0, go to IDLE.
  - ACC without prod_vld: hold all state. No timeout.
- Completion latency: the final sum appears on sum_out, with sum_vld=1, on the cycle after the final prod_vld.
- Output register:
  - sum_vld && sum_rdy at a clock edge: handshake completes, sum_vld clears unless a new sum is loaded on the same edge.
  - Completion when sum_vld==0, or when sum_vld && sum_rdy (simultaneous): load the new sum; sum_vld=1.
  - Completion when sum_vld && !sum_rdy: the new sum is discarded, sum_out/sum_vld are unchanged, ovr is set.
  - ovr clears only on rst.
  - sum_out is stable while sum_vld && !sum_rdy.
- clr:
  - Forces acc=0, term_cnt=0, state=IDLE.
  - Takes priority over a same-cycle prod_vld; that product is discarded.
  - Does not affect sum_out, sum_vld or ovr.
- Arithmetic:
  - Unsigned, no saturation.
  - Max product is 255*255 = 65025, so the width rule guarantees no wrap.
- Back-to-back prod_vld every cycle is supported.
- Reset asserted mid-vector: partial acc is lost and sum_vld drops immediately (asynchronous).

Decomposition:
- Shared package holds:
  - PROD_W = 16.
  - MAX_PROD = 65025.
  - The FSM state typedef {IDLE, ACC}.
  - A clog2 helper for the term_cnt width.
- Sub-module dot_acc8_outreg: the single-entry valid/ready output register with overrun detection.
  - Inputs: load, data, rdy.
  - Outputs: data, vld, ovr.
  - Reusable for other fixed-rate datapath stages.
- Accumulator and FSM stay in the top module.

Test Plan:
- Products 1,2,...,8 on consecutive cycles, sum_rdy=1 -> one cycle after the 8th strobe: sum_out=36, sum_vld=1 for one cycle, ovr=0.
- Eight products of 65025 spaced 11 cycles apart (multiplier rate) -> sum_out=520200 (0x7F008), no wrap. busy=1 from the first strobe until completion.
- Vector A (all 100) completes with sum_rdy=0 -> sum_out=800 and held. Vector B (all 2) then completes, still sum_rdy=0 -> sum_out stays 800, ovr=1. sum_rdy=1 -> sum_vld clears the next edge.
- Completion of vector B (sum 16) on the same edge as the handshake of A -> sum_out=16, sum_vld stays 1, ovr=0.
- Three products of 50, then clr with a simultaneous prod_vld=70, then eight products of 10 -> sum_out=80; term_cnt reads 0 after clr.
- rst pulsed after four products, asynchronously mid-cycle -> all outputs 0 immediately. A fresh vector of eight 5s -> sum_out=40.

Source files
------------

// File: rtl/dot_acc8_pkg.sv
// Shared definitions for the dot-product accumulator: product width, state type, width helper.
package dot_acc8_pkg;

  localparam int unsigned PROD_W   = 16;
  localparam int unsigned MAX_PROD = 65025;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dot_acc8_outreg.sv
// Single-entry valid/ready output register; a load while full and not draining is dropped and flagged.
module dot_acc8_outreg #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         rdy,
  output logic [W-1:0] out_data,
  output logic         vld,
  output logic         ovr
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;
  logic         ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  // A handshake on the same edge frees the slot for the incoming load.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (vld_q && rdy) vld_d = 1'b0;
    if (load) begin
      if (!vld_q || rdy) begin
        data_d = in_data;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign out_data = data_q;
  assign vld      = vld_q;
  assign ovr      = ovr_q;

endmodule

// File: rtl/dot_acc8.sv
// Accumulates N_TERMS unsigned products into a sum and hands each sum to a valid/ready output register.
module dot_acc8
  import dot_acc8_pkg::*;
#(
  parameter  int unsigned N_TERMS = 8,
  parameter  int unsigned ACC_W   = 20,
  localparam int unsigned CNT_W   = clog2_f(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_vld,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_vld,
  input  logic              sum_rdy,
  output logic              busy,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovr
);

  if (N_TERMS < 2 || N_TERMS > 256) begin : g_bad_terms
    $error("dot_acc8: N_TERMS must be in 2..256");
  end
  if (ACC_W < PROD_W + CNT_W) begin : g_bad_width
    $error("dot_acc8: ACC_W too narrow for N_TERMS full-scale products");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_c;
  logic             done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr wins over a same-cycle product; the last product of a vector returns to IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    sum_c   = acc_q + ACC_W'(prod_in);
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (prod_vld) begin
      case (state_q)
        IDLE: begin
          state_d = ACC;
          acc_d   = ACC_W'(prod_in);
          cnt_d   = CNT_W'(1);
        end
        ACC: begin
          if (cnt_q == CNT_W'(N_TERMS - 1)) begin
            done_c  = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ACC);
  assign term_cnt = cnt_q;

  dot_acc8_outreg #(.W(ACC_W)) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load     (done_c),
    .in_data  (sum_c),
    .rdy      (sum_rdy),
    .out_data (sum_out),
    .vld      (sum_vld),
    .ovr      (ovr)
  );

endmodule

// File: tb/tb_dot_acc8.sv
// Self-checking bench for dot_acc8: vector table, corner-case sequences, randomized traffic vs. a reference model.
module tb_dot_acc8;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prod_in;
  logic        prod_vld;
  logic        clr;
  logic [19:0] sum_out;
  logic        sum_vld;
  logic        sum_rdy;
  logic        busy;
  logic [2:0]  term_cnt;
  logic        ovr;

  int checks   = 0;
  int failures = 0;

  // Reference model: partial vector as a list of products, plus one output slot.
  int unsigned part_q[$];
  int unsigned m_sum;
  bit          m_vld;
  bit          m_ovr;

  typedef struct {
    int unsigned prods[N];
    int          gap;
    int unsigned exp_sum;
  } vec_t;

  dot_acc8 #(.N_TERMS(8), .ACC_W(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .prod_in  (prod_in),
    .prod_vld (prod_vld),
    .clr      (clr),
    .sum_out  (sum_out),
    .sum_vld  (sum_vld),
    .sum_rdy  (sum_rdy),
    .busy     (busy),
    .term_cnt (term_cnt),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    m_sum = 0;
    m_vld = 0;
    m_ovr = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sum_out"}, sum_out, m_sum);
    chk({tag, ".sum_vld"}, sum_vld, m_vld);
    chk({tag, ".ovr"}, ovr, m_ovr);
    chk({tag, ".busy"}, busy, part_q.size() != 0);
    chk({tag, ".term_cnt"}, term_cnt, part_q.size());
  endtask

  // One clock: capture inputs, advance the model, compare all outputs after the edge.
  task automatic tick(input string tag);
    bit          c_clr = clr;
    bit          c_vld = prod_vld;
    bit          c_rdy = sum_rdy;
    int unsigned c_p   = prod_in;
    bit          done  = 0;
    bit          old_vld;
    int unsigned s     = 0;
    @(posedge clk);
    #1;
    if (c_clr) part_q.delete();
    else if (c_vld) begin
      part_q.push_back(c_p);
      if (part_q.size() == N) begin
        done = 1;
        foreach (part_q[i]) s += part_q[i];
        part_q.delete();
      end
    end
    old_vld = m_vld;
    if (m_vld && c_rdy) m_vld = 0;
    if (done) begin
      if (!old_vld || c_rdy) begin
        m_sum = s;
        m_vld = 1;
      end else m_ovr = 1;
    end
    chk_all(tag);
  endtask

  task automatic put(input int unsigned p, input string tag);
    prod_vld = 1'b1;
    prod_in  = 16'(p);
    tick(tag);
    prod_vld = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    tick("post_reset");
  endtask

  vec_t vecs[4];

  initial begin
    rst      = 1'b1;
    prod_in  = '0;
    prod_vld = 1'b0;
    clr      = 1'b0;
    sum_rdy  = 1'b1;
    model_reset();
    #3;
    chk_all("reset");
    #14;
    rst = 1'b0;
    tick("release");

    for (int i = 0; i < N; i++) begin
      vecs[0].prods[i] = i + 1;
      vecs[1].prods[i] = 65025;
      vecs[2].prods[i] = 5;
      vecs[3].prods[i] = (i % 2 == 0) ? 65025 : 0;
    end
    vecs[0].gap = 0;  vecs[0].exp_sum = 36;
    vecs[1].gap = 10; vecs[1].exp_sum = 520200;
    vecs[2].gap = 1;  vecs[2].exp_sum = 40;
    vecs[3].gap = 0;  vecs[3].exp_sum = 260100;

    sum_rdy = 1'b1;
    foreach (vecs[v]) begin
      for (int i = 0; i < N; i++) begin
        put(vecs[v].prods[i], "table");
        if (i != N - 1) idle(vecs[v].gap, "table_gap");
      end
      chk("table.sum", sum_out, vecs[v].exp_sum);
      chk("table.vld", sum_vld, 1);
      chk("table.ovr", ovr, 0);
      tick("table_drain");
      chk("table.vld_one_cycle", sum_vld, 0);
    end

    // Overrun: A held with rdy low, B dropped.
    sum_rdy = 1'b0;
    for (int i = 0; i < N; i++) put(100, "ovr_a");
    chk("ovr.a_sum", sum_out, 800);
    for (int i = 0; i < N; i++) put(2, "ovr_b");
    chk("ovr.held_sum", sum_out, 800);
    chk("ovr.flag", ovr, 1);
    chk("ovr.vld", sum_vld, 1);
    sum_rdy = 1'b1;
    tick("ovr_drain");
    chk("ovr.drained", sum_vld, 0);
    chk("ovr.sticky", ovr, 1);

    // Completion of B on the same edge as A's handshake.
    sync_reset();
    sum_rdy = 1'b0;
    for (int i = 0; i < N; i++) put(100, "sim_a");
    for (int i = 0; i < N - 1; i++) put(2, "sim_b");
    sum_rdy = 1'b1;
    put(2, "sim_b_last");
    chk("sim.sum", sum_out, 16);
    chk("sim.vld", sum_vld, 1);
    chk("sim.ovr", ovr, 0);
    tick("sim_drain");

    // clr beats a simultaneous product.
    for (int i = 0; i < 3; i++) put(50, "clr_pre");
    clr = 1'b1;
    put(70, "clr");
    clr = 1'b0;
    chk("clr.term_cnt", term_cnt, 0);
    chk("clr.busy", busy, 0);
    for (int i = 0; i < N; i++) put(10, "clr_post");
    chk("clr.sum", sum_out, 80);

    // Asynchronous reset mid-vector.
    for (int i = 0; i < 4; i++) put(9, "arst_pre");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.sum_out", sum_out, 0);
    chk("arst.sum_vld", sum_vld, 0);
    chk("arst.busy", busy, 0);
    chk("arst.term_cnt", term_cnt, 0);
    chk("arst.ovr", ovr, 0);
    #1;
    rst = 1'b0;
    tick("arst_release");
    for (int i = 0; i < N; i++) put(5, "arst_fresh");
    chk("arst.fresh_sum", sum_out, 40);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      prod_vld = ($urandom_range(0, 99) < 60);
      prod_in  = 16'($urandom_range(0, 65025));
      clr      = ($urandom_range(0, 99) < 3);
      sum_rdy  = ($urandom_range(0, 99) < 55);
      tick("rand");
    end
    prod_vld = 1'b0;
    clr      = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
